// File: rtl/conv_x_source.sv
// Frame buffer that loads SIZE_X samples, then streams them in order toward the
// convolution x port on request; the stored frame can be resent until reloaded.
module conv_x_source #(
    parameter int T      = 16,
    parameter int SIZE_X = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         start,
    input  logic         reload,
    output logic [T-1:0] x_data,
    output logic         x_valid,
    input  logic         x_ready,
    output logic         busy,
    output logic         frame_done,
    output logic [1:0]   o_dbg_state
);

    localparam int AW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
    localparam int PW = $clog2(SIZE_X + 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_LOADED = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    // Handshake: a sample moves on every posedge where x_valid and x_ready are
    // both high; once x_valid rises, x_data/x_valid hold until that happens.

    state_t        r_state;
    state_t        w_next;
    logic [T-1:0]  r_mem [SIZE_X];
    logic [AW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [T-1:0]  r_x_data;
    logic          r_x_valid;
    logic          r_frame_done;

    logic          w_wr_en;
    logic          w_wr_last;
    logic          w_xfer;
    logic          w_xfer_last;
    logic          w_start_send;
    logic          w_load_x;
    logic [AW-1:0] w_rd_addr;

    assign w_wr_en      = (r_state == S_LOAD) && in_valid;
    assign w_wr_last    = w_wr_en && (r_wr_ptr == AW'(SIZE_X - 1));
    assign w_xfer       = r_x_valid && x_ready;
    // r_rd_ptr runs one ahead of the presented sample, so SIZE_X marks the last one
    assign w_xfer_last  = w_xfer && (r_rd_ptr == PW'(SIZE_X));
    assign w_start_send = (r_state == S_LOADED) && start;
    assign w_load_x     = w_start_send || (w_xfer && !w_xfer_last);
    assign w_rd_addr    = w_start_send ? '0 : r_rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_wr_last) begin
                    w_next = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start) begin
                    w_next = S_SEND;
                end else if (reload) begin
                    w_next = S_LOAD;
                end
            end
            S_SEND: begin
                if (w_xfer_last) begin
                    w_next = S_LOADED;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Prefetch: the next sample is read into the output register on the same
    // edge that retires the current one, so back-to-back transfers have no gaps.
    always_ff @(posedge clk) begin
        if (w_load_x) begin
            r_x_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer_last;
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_start_send) begin
                r_x_valid <= 1'b1;
                r_rd_ptr  <= PW'(1);
            end else if (w_xfer) begin
                if (w_xfer_last) begin
                    r_x_valid <= 1'b0;
                    r_rd_ptr  <= '0;
                end else begin
                    r_rd_ptr  <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    assign in_ready    = (r_state == S_LOAD);
    assign busy        = (r_state == S_SEND);
    assign x_data      = r_x_data;
    assign x_valid     = r_x_valid;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_x_source.sv
// Randomized bench for conv_x_source: a frame model and an expected-sample
// queue are compared against everything the block streams out.
module tb_conv_x_source;

    localparam int T      = 16;
    localparam int SIZE_X = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [T-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         start;
    logic         reload;
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic         busy;
    logic         frame_done;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int rx_count = 0;
    bit mon_en   = 1'b0;

    logic [T-1:0] model_buf [SIZE_X];
    logic [T-1:0] exp_q [$];

    conv_x_source #(.T(T), .SIZE_X(SIZE_X)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .reload     (reload),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the head of exp_q; stalled
    // samples must not change; frame_done must be a single-cycle pulse.
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic         prev_reset = 1'b0;
    logic         prev_fd    = 1'b0;
    logic [T-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_valid && !prev_ready && !prev_reset) begin
                check("stall_valid", 32'(x_valid), 32'd1);
                check("stall_data", 32'(x_data), 32'(prev_data));
            end
            if (x_valid && x_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    check("x_data", 32'(x_data), 32'(exp_q.pop_front()));
                end
                rx_count++;
            end
            if (frame_done) begin
                check("fd_single", 32'(prev_fd), 32'd0);
            end
        end
        prev_valid = x_valid;
        prev_ready = x_ready;
        prev_reset = reset;
        prev_fd    = frame_done;
        prev_data  = x_data;
    end

    // Load model_buf with random in_valid gaps; start/reload toggle randomly
    // and must be ignored while loading.
    task automatic load_frame(input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < SIZE_X && guard < 2000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = in_valid ? model_buf[i] : T'($urandom);
            start    = 1'($urandom_range(0, 1));
            reload   = 1'($urandom_range(0, 1));
            check("load_in_ready", 32'(in_ready), 32'd1);
            check("load_no_xvalid", 32'(x_valid), 32'd0);
            tick();
            if (in_valid) i++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        reload   = 1'b0;
        check("loaded_in_ready", 32'(in_ready), 32'd0);
        check("loaded_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_xvalid", 32'(x_valid), 32'd0);
    endtask

    task automatic send_frame(input int ready_pct, input bit contig, input int stall, input bit both);
        int cyc = 0;
        for (int i = 0; i < SIZE_X; i++) exp_q.push_back(model_buf[i]);
        x_ready = 1'b0;
        start   = 1'b1;
        reload  = both;
        tick();
        start  = 1'b0;
        reload = 1'b0;
        if (!x_valid) tick();
        check("xv_latency", 32'(x_valid), 32'd1);
        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_hold_valid", 32'(x_valid), 32'd1);
            check("stall_hold_data", 32'(x_data), 32'(model_buf[0]));
        end
        while (!frame_done && cyc < 500) begin
            x_ready = ($urandom_range(0, 99) < ready_pct);
            check("send_busy", 32'(busy), 32'd1);
            check("send_in_ready", 32'(in_ready), 32'd0);
            tick();
            cyc++;
        end
        x_ready = 1'b0;
        check("frame_done", 32'(frame_done), 32'd1);
        if (contig) check("no_bubble_cycles", 32'(cyc), 32'(SIZE_X));
        check("all_received", 32'(exp_q.size()), 32'd0);
        check("done_xvalid", 32'(x_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        tick();
        check("fd_cleared", 32'(frame_done), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int base;
        int cyc;
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        start    = 1'b0;
        reload   = 1'b0;
        x_ready  = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_xvalid", 32'(x_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_start_xvalid", 32'(x_valid), 32'd0);
        check("load_start_busy", 32'(busy), 32'd0);
        tick();
        check("load_start_xvalid2", 32'(x_valid), 32'd0);
        check("load_start_in_ready", 32'(in_ready), 32'd1);

        // Ramp 0..31, full-rate send, then an identical resend.
        for (int i = 0; i < SIZE_X; i++) model_buf[i] = T'(i);
        load_frame(0);
        send_frame(100, 1'b1, 0, 1'b0);
        send_frame(100, 1'b1, 0, 1'b0);

        // Signed pattern with input gaps and a 50% downstream ready.
        do_reload();
        model_buf[0] = T'(-147);
        model_buf[1] = T'(76);
        for (int i = 2; i < SIZE_X; i++) model_buf[i] = T'($urandom);
        load_frame(30);
        send_frame(50, 1'b0, 0, 1'b0);
        send_frame(50, 1'b0, 0, 1'b1);

        // Ten-cycle stall on an all-ones first sample.
        do_reload();
        for (int i = 0; i < SIZE_X; i++) model_buf[i] = T'($urandom);
        model_buf[0] = 16'hFFFF;
        load_frame(10);
        send_frame(100, 1'b0, 10, 1'b0);

        // Reset after 15 transfers, then a fresh frame.
        for (int i = 0; i < SIZE_X; i++) exp_q.push_back(model_buf[i]);
        base  = rx_count;
        start = 1'b1;
        tick();
        start   = 1'b0;
        x_ready = 1'b1;
        cyc     = 0;
        while ((rx_count - base) < 15 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("pre_reset_xfers", 32'(rx_count - base), 32'd15);
        reset   = 1'b1;
        x_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_xvalid", 32'(x_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < SIZE_X; i++) model_buf[i] = T'(100 + i);
        load_frame(20);
        send_frame(70, 1'b0, 0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            do_reload();
            for (int i = 0; i < SIZE_X; i++) model_buf[i] = T'($urandom);
            load_frame($urandom_range(0, 60));
            send_frame($urandom_range(20, 100), 1'b0, 0, 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
